// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// ready-handshaked memory, with optional memory timeout, illegal-opcode flag and retire counter.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_instr,
  output logic                ir_write,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal_op,
  output logic                mem_err,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_BEQ, OP_BLT, OP_BGE, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_STOP
  } op_t;

  // wait_cnt only ever needs to hold 0..MEM_TIMEOUT-1
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t              state, next_state;
  op_t                 op_q;
  op_t                 op_in;
  logic                op_illegal;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [RETIRE_W-1:0] retired_q;
  logic                mem_err_q;
  logic                mem_busy;
  logic                timeout;
  logic                retire;

  function automatic logic [3:0] alu_code(input op_t op);
    logic [3:0] code;
    code = 4'h0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_XOR, OP_NOT: code = op;
      OP_BEQ:                        code = 4'h1;
      OP_BLT, OP_BGE:                code = 4'h8;
      default:                       code = 4'h0;
    endcase
    return code;
  endfunction

  assign op_in      = op_t'(opcode[3:0]);
  assign op_illegal = (opcode >> 4) != '0;
  assign mem_busy   = (state == S_FETCH) || (state == S_MEM);
  assign timeout    = (MEM_TIMEOUT > 0) && mem_busy && !mem_ready &&
                      (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= OP_ADD;
      wait_cnt  <= '0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        op_q <= op_in;
      if (!mem_busy || mem_ready)
        wait_cnt <= '0;
      else if ((MEM_TIMEOUT > 0) && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        mem_err_q <= 1'b1;
      if (retire)
        retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (timeout)        next_state = S_HALT;
        else if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (op_illegal)            next_state = S_FETCH;
        else if (op_in == OP_STOP) next_state = S_HALT;
        else                       next_state = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: next_state = S_MEM;
          OP_BEQ, OP_BLT, OP_BGE, OP_JAL, OP_JALR: begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          default: next_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          next_state = S_HALT;
        end else if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Everything is gated by rst_n so the datapath sees no enables during reset.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_instr  = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    mem_err    = 1'b0;
    retired    = '0;
    if (rst_n) begin
      mem_err = mem_err_q;
      retired = retired_q;
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          mem_instr = 1'b1;
          ir_write  = mem_ready;
          pc_inc    = mem_ready;
        end
        S_DECODE: illegal_op = op_illegal;
        S_EXEC: begin
          alu_op  = ALUOP_W'(alu_code(op_q));
          alu_src = op_q inside {OP_LOAD, OP_STORE, OP_JAL, OP_JALR};
          case (op_q)
            OP_BEQ: pc_load = alu_zero;
            OP_BLT: pc_load = alu_neg;
            OP_BGE: pc_load = !alu_neg;
            OP_JAL, OP_JALR: begin
              pc_load   = 1'b1;
              reg_write = 1'b1;
            end
            default: pc_load = 1'b0;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_q == OP_STORE);
          alu_src = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LOAD);
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with OPCODE_W=6 and MEM_TIMEOUT=8;
// control outputs are packed into one word and compared against hand-built masks.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        alu_neg;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_instr, ir_write, pc_inc, pc_load;
  logic        reg_write, mem_to_reg, alu_src, illegal_op, mem_err, halted;
  logic [3:0]  alu_op;
  logic [15:0] retired;
  logic [11:0] ctl;
  logic [15:0] r_exp;
  int unsigned errors;
  int unsigned checks;

  localparam logic [11:0] C_REQ = 12'h800, C_WE  = 12'h400, C_INS = 12'h200,
                          C_IRW = 12'h100, C_PCI = 12'h080, C_PCL = 12'h040,
                          C_RW  = 12'h020, C_M2R = 12'h010, C_SRC = 12'h008,
                          C_ILL = 12'h004, C_ERR = 12'h002, C_HLT = 12'h001;

  multicycle_control_fsm #(
    .OPCODE_W(6), .ALUOP_W(4), .MEM_TIMEOUT(8), .RETIRE_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_instr(mem_instr), .ir_write(ir_write),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_err(mem_err), .halted(halted),
    .retired(retired)
  );

  assign ctl = {mem_req, mem_we, mem_instr, ir_write, pc_inc, pc_load,
                reg_write, mem_to_reg, alu_src, illegal_op, mem_err, halted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; alu_zero = 1'b0; alu_neg = 1'b0;
    r_exp = '0;
    tick; tick; #1;
    checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reset_ctl: ctl=%03h expected %03h", ctl, 12'h000); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    checks++; if (ctl !== (C_REQ | C_INS)) begin errors++; $display("FAIL reset_fetch: ctl=%03h expected %03h", ctl, C_REQ | C_INS); end
  endtask

  task automatic run_alu(input logic [5:0] op);
    opcode = op; mem_ready = 1'b1; alu_zero = 1'b0; alu_neg = 1'b0; #1;
    checks++; if (ctl !== (C_REQ | C_INS | C_IRW | C_PCI)) begin errors++; $display("FAIL alu_fetch op=%0h: ctl=%03h expected %03h", op, ctl, C_REQ | C_INS | C_IRW | C_PCI); end
    tick;
    checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL alu_decode op=%0h: ctl=%03h expected 000", op, ctl); end
    tick;
    checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL alu_exec op=%0h: ctl=%03h expected 000", op, ctl); end
    checks++; if (alu_op !== op[3:0]) begin errors++; $display("FAIL alu_exec_op op=%0h: alu_op=%0h expected %0h", op, alu_op, op[3:0]); end
    tick;
    checks++; if (ctl !== C_RW) begin errors++; $display("FAIL alu_wb op=%0h: ctl=%03h expected %03h", op, ctl, C_RW); end
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL alu_wb_retired op=%0h: got %0d expected %0d", op, retired, r_exp); end
    tick;
    r_exp++;
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL alu_retire op=%0h: got %0d expected %0d", op, retired, r_exp); end
  endtask

  task automatic test_back_to_back;
    for (int op = 0; op < 8; op++) run_alu(6'(op));
  endtask

  task automatic test_load;
    opcode = 6'h0B; mem_ready = 1'b1; #1;
    tick; tick;
    checks++; if (ctl !== C_SRC) begin errors++; $display("FAIL load_exec: ctl=%03h expected %03h", ctl, C_SRC); end
    checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL load_alu_op: alu_op=%0h expected 0", alu_op); end
    mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_ready = 1'b1; #1; end
      checks++; if (ctl !== (C_REQ | C_SRC)) begin errors++; $display("FAIL load_mem cyc=%0d: ctl=%03h expected %03h", i, ctl, C_REQ | C_SRC); end
      tick;
    end
    checks++; if (ctl !== (C_RW | C_M2R)) begin errors++; $display("FAIL load_wb: ctl=%03h expected %03h", ctl, C_RW | C_M2R); end
    tick;
    r_exp++;
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL load_retire: got %0d expected %0d", retired, r_exp); end
    checks++; if (ctl !== (C_REQ | C_INS | C_IRW | C_PCI)) begin errors++; $display("FAIL load_next_fetch: ctl=%03h expected %03h", ctl, C_REQ | C_INS | C_IRW | C_PCI); end
  endtask

  task automatic test_store;
    opcode = 6'h0C; mem_ready = 1'b1; #1;
    tick; tick;
    checks++; if (ctl !== C_SRC) begin errors++; $display("FAIL store_exec: ctl=%03h expected %03h", ctl, C_SRC); end
    tick;
    checks++; if (ctl !== (C_REQ | C_WE | C_SRC)) begin errors++; $display("FAIL store_mem: ctl=%03h expected %03h", ctl, C_REQ | C_WE | C_SRC); end
    tick;
    r_exp++;
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL store_retire: got %0d expected %0d", retired, r_exp); end
  endtask

  task automatic run_branch(input logic [5:0] op, input logic z, input logic n,
                            input logic [11:0] exp_ctl, input logic [3:0] exp_op);
    opcode = op; mem_ready = 1'b1; alu_zero = 1'b0; alu_neg = 1'b0; #1;
    tick; tick;
    alu_zero = z; alu_neg = n; #1;
    checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL branch_exec op=%0h z=%0b n=%0b: ctl=%03h expected %03h", op, z, n, ctl, exp_ctl); end
    checks++; if (alu_op !== exp_op) begin errors++; $display("FAIL branch_alu_op op=%0h: alu_op=%0h expected %0h", op, alu_op, exp_op); end
    tick;
    r_exp++;
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL branch_retire op=%0h: got %0d expected %0d", op, retired, r_exp); end
  endtask

  task automatic test_branch;
    run_branch(6'h08, 1'b1, 1'b0, C_PCL, 4'h1);
    run_branch(6'h08, 1'b0, 1'b0, 12'h000, 4'h1);
    run_branch(6'h0A, 1'b0, 1'b0, C_PCL, 4'h8);
    run_branch(6'h0A, 1'b0, 1'b1, 12'h000, 4'h8);
    run_branch(6'h09, 1'b0, 1'b0, 12'h000, 4'h8);
    run_branch(6'h09, 1'b0, 1'b1, C_PCL, 4'h8);
    run_branch(6'h0D, 1'b0, 1'b0, C_PCL | C_RW | C_SRC, 4'h0);
    run_branch(6'h0E, 1'b1, 1'b1, C_PCL | C_RW | C_SRC, 4'h0);
  endtask

  task automatic test_stop;
    opcode = 6'h0F; mem_ready = 1'b1; #1;
    tick;
    checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL stop_decode: ctl=%03h expected 000", ctl); end
    tick;
    checks++; if (ctl !== C_HLT) begin errors++; $display("FAIL stop_halt: ctl=%03h expected %03h", ctl, C_HLT); end
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++; if (ctl !== C_HLT || retired !== r_exp) begin errors++; $display("FAIL stop_idle cyc=%0d: ctl=%03h retired=%0d expected %03h/%0d", i, ctl, retired, C_HLT, r_exp); end
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; mem_ready = 1'b0; r_exp = '0; #1;
    checks++; if (ctl !== (C_REQ | C_INS)) begin errors++; $display("FAIL stop_reset_fetch: ctl=%03h expected %03h", ctl, C_REQ | C_INS); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL stop_reset_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0; opcode = '0; #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (ctl !== (C_REQ | C_INS)) begin errors++; $display("FAIL timeout_wait cyc=%0d: ctl=%03h expected %03h", i, ctl, C_REQ | C_INS); end
      tick;
    end
    checks++; if (ctl !== (C_ERR | C_HLT)) begin errors++; $display("FAIL timeout_halt: ctl=%03h expected %03h", ctl, C_ERR | C_HLT); end
    tick;
    checks++; if (ctl !== (C_ERR | C_HLT)) begin errors++; $display("FAIL timeout_sticky: ctl=%03h expected %03h", ctl, C_ERR | C_HLT); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; #1;
    checks++; if (ctl !== (C_REQ | C_INS)) begin errors++; $display("FAIL timeout_reset: ctl=%03h expected %03h", ctl, C_REQ | C_INS); end
    for (int i = 0; i < 7; i++) tick;
    mem_ready = 1'b1; #1;
    checks++; if (ctl !== (C_REQ | C_INS | C_IRW | C_PCI)) begin errors++; $display("FAIL timeout_last_ready: ctl=%03h expected %03h", ctl, C_REQ | C_INS | C_IRW | C_PCI); end
    tick;
    checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL timeout_decode: ctl=%03h expected 000", ctl); end
    tick; tick; tick;
    r_exp++;
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL timeout_retire: got %0d expected %0d", retired, r_exp); end
  endtask

  task automatic test_illegal;
    opcode = 6'b010000; mem_ready = 1'b1; #1;
    tick;
    checks++; if (ctl !== C_ILL) begin errors++; $display("FAIL illegal_decode: ctl=%03h expected %03h", ctl, C_ILL); end
    tick;
    mem_ready = 1'b0; #1;
    checks++; if (ctl !== (C_REQ | C_INS)) begin errors++; $display("FAIL illegal_refetch: ctl=%03h expected %03h", ctl, C_REQ | C_INS); end
    checks++; if (retired !== r_exp) begin errors++; $display("FAIL illegal_retired: got %0d expected %0d", retired, r_exp); end
  endtask

  task automatic test_reset_mid_mem;
    opcode = 6'h0C; mem_ready = 1'b1; #1;
    tick; tick;
    mem_ready = 1'b0;
    tick;
    checks++; if (ctl !== (C_REQ | C_WE | C_SRC)) begin errors++; $display("FAIL midmem_wait: ctl=%03h expected %03h", ctl, C_REQ | C_WE | C_SRC); end
    rst_n = 1'b0; #1;
    checks++; if (ctl !== 12'h000 || retired !== 16'd0) begin errors++; $display("FAIL midmem_gated: ctl=%03h retired=%0d expected 000/0", ctl, retired); end
    tick;
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    checks++; if (ctl !== (C_REQ | C_INS | C_IRW | C_PCI)) begin errors++; $display("FAIL midmem_fetch: ctl=%03h expected %03h", ctl, C_REQ | C_INS | C_IRW | C_PCI); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL midmem_retired: got %0d expected 0", retired); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_back_to_back;
    test_load;
    test_store;
    test_branch;
    test_stop;
    test_timeout;
    test_illegal;
    test_reset_mid_mem;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
